cu_id_decoder: RTL and testbench

Single-cycle registered RV32I instruction decoder inside the control unit. It sits between the instruction register and the CU sequencer. On a `decode_start` request it decodes the 32-bit `Cu_IR` into a CU instruction ID, an ALU opcode, register selects, a sign-extended immediate, a shift amount and a PC increment. It also flags read-after-write hazards against the previously decoded instruction and reports illegal encodings.

---
 rtl/cu_id_decoder_if.sv | 30 +++
 rtl/cu_id_decoder.sv | 176 +++++++++++++++++
 tb/tb_cu_id_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cu_id_decoder_if.sv
// Decode-request and decoded-result bundle between the CU sequencer and the ID decoder.
// The sequencer side is the master; the decoder side is the slave.
interface cu_id_decoder_if;
    logic        decode_start;
    logic        IDU_stall;
    logic [31:0] Cu_IR;
    logic        IDU_ready;
    logic [5:0]  Instruction_to_CU;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic [31:0] pc_increment;
    logic [1:0]  pipeline_override;
    logic        invalid_instruction;

    modport master (
        output decode_start, IDU_stall, Cu_IR,
        input  IDU_ready, Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2,
               shamt, pc_increment, pipeline_override, invalid_instruction
    );

    modport slave (
        input  decode_start, IDU_stall, Cu_IR,
        output IDU_ready, Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2,
               shamt, pc_increment, pipeline_override, invalid_instruction
    );
endinterface

// File: rtl/cu_id_decoder.sv
// Registered RV32I decoder: turns Cu_IR into CU/ALU codes, register selects and immediates,
// and flags RAW hazards against the register written by the previous accepted decode.
module cu_id_decoder (
    input logic           soc_clk,
    input logic           reset,
    cu_id_decoder_if.slave idu
);
    localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_EQ   = 5'd10, ALU_NE   = 5'd11;
    localparam logic [4:0] ALU_LT   = 5'd12, ALU_GE   = 5'd13, ALU_LTU  = 5'd14, ALU_GEU  = 5'd15;
    localparam logic [4:0] ALU_PASS_B = 5'd16, ALU_NONE = 5'd31;

    logic [31:0] ir;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [5:0]  d_id;
    logic [4:0]  d_alu, d_rd, d_rs1, d_rs2, d_shamt;
    logic [31:0] d_imm, d_pc;
    logic [1:0]  d_ovr;
    logic        d_inv, use_rd, use_rs1, use_rs2, use_shamt;

    logic        ready_q, inv_q;
    logic [5:0]  id_q;
    logic [4:0]  alu_q, rd_q, rs1_q, rs2_q, shamt_q, prev_rd;
    logic [31:0] imm_q, pc_q;
    logic [1:0]  ovr_q;
    logic        accept;

    assign ir     = idu.Cu_IR;
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign accept = idu.decode_start & ~idu.IDU_stall;

    always_comb begin
        d_id = 6'd0; d_alu = ALU_NONE; d_imm = 32'd0; d_pc = 32'd4; d_inv = 1'b0;
        use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_shamt = 1'b0;
        if (ir[1:0] != 2'b11) begin
            d_inv = 1'b1;
        end else begin
            case (opcode)
                7'b0110111: begin d_id = 6'd1; d_alu = ALU_PASS_B; d_imm = imm_u; use_rd = 1'b1; end
                7'b0010111: begin d_id = 6'd2; d_alu = ALU_ADD; d_imm = imm_u; use_rd = 1'b1; end
                7'b1101111: begin
                    d_id = 6'd3; d_alu = ALU_ADD; d_imm = imm_j; d_pc = imm_j; use_rd = 1'b1;
                end
                7'b1100111: begin
                    d_id = 6'd4; d_alu = ALU_ADD; d_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
                    d_inv = (funct3 != 3'b000);
                end
                7'b1100011: begin
                    d_imm = imm_b; d_pc = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    case (funct3)
                        3'b000:  begin d_id = 6'd5;  d_alu = ALU_EQ;  end
                        3'b001:  begin d_id = 6'd6;  d_alu = ALU_NE;  end
                        3'b100:  begin d_id = 6'd7;  d_alu = ALU_LT;  end
                        3'b101:  begin d_id = 6'd8;  d_alu = ALU_GE;  end
                        3'b110:  begin d_id = 6'd9;  d_alu = ALU_LTU; end
                        3'b111:  begin d_id = 6'd10; d_alu = ALU_GEU; end
                        default: d_inv = 1'b1;
                    endcase
                end
                7'b0000011: begin
                    d_alu = ALU_ADD; d_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
                    case (funct3)
                        3'b000:  d_id = 6'd11;
                        3'b001:  d_id = 6'd12;
                        3'b010:  d_id = 6'd13;
                        3'b100:  d_id = 6'd14;
                        3'b101:  d_id = 6'd15;
                        default: d_inv = 1'b1;
                    endcase
                end
                7'b0100011: begin
                    d_alu = ALU_ADD; d_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    case (funct3)
                        3'b000:  d_id = 6'd16;
                        3'b001:  d_id = 6'd17;
                        3'b010:  d_id = 6'd18;
                        default: d_inv = 1'b1;
                    endcase
                end
                7'b0010011: begin
                    d_imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
                    case (funct3)
                        3'b000: begin d_id = 6'd19; d_alu = ALU_ADD;  end
                        3'b010: begin d_id = 6'd20; d_alu = ALU_SLT;  end
                        3'b011: begin d_id = 6'd21; d_alu = ALU_SLTU; end
                        3'b100: begin d_id = 6'd22; d_alu = ALU_XOR;  end
                        3'b110: begin d_id = 6'd23; d_alu = ALU_OR;   end
                        3'b111: begin d_id = 6'd24; d_alu = ALU_AND;  end
                        3'b001: begin
                            d_id = 6'd25; d_alu = ALU_SLL; use_shamt = 1'b1;
                            d_inv = (funct7 != 7'b0000000);
                        end
                        default: begin
                            use_shamt = 1'b1;
                            if (funct7 == 7'b0000000)      begin d_id = 6'd26; d_alu = ALU_SRL; end
                            else if (funct7 == 7'b0100000) begin d_id = 6'd27; d_alu = ALU_SRA; end
                            else                           d_inv = 1'b1;
                        end
                    endcase
                end
                7'b0110011: begin
                    use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                    case ({funct7, funct3})
                        {7'b0000000, 3'b000}: begin d_id = 6'd28; d_alu = ALU_ADD;  end
                        {7'b0100000, 3'b000}: begin d_id = 6'd29; d_alu = ALU_SUB;  end
                        {7'b0000000, 3'b001}: begin d_id = 6'd30; d_alu = ALU_SLL;  end
                        {7'b0000000, 3'b010}: begin d_id = 6'd31; d_alu = ALU_SLT;  end
                        {7'b0000000, 3'b011}: begin d_id = 6'd32; d_alu = ALU_SLTU; end
                        {7'b0000000, 3'b100}: begin d_id = 6'd33; d_alu = ALU_XOR;  end
                        {7'b0000000, 3'b101}: begin d_id = 6'd34; d_alu = ALU_SRL;  end
                        {7'b0100000, 3'b101}: begin d_id = 6'd35; d_alu = ALU_SRA;  end
                        {7'b0000000, 3'b110}: begin d_id = 6'd36; d_alu = ALU_OR;   end
                        {7'b0000000, 3'b111}: begin d_id = 6'd37; d_alu = ALU_AND;  end
                        default:              d_inv = 1'b1;
                    endcase
                end
                7'b0001111: begin d_id = 6'd38; d_inv = (funct3 != 3'b000); end
                7'b1110011: begin
                    if (ir == 32'h0000_0073)      d_id = 6'd39;
                    else if (ir == 32'h0010_0073) d_id = 6'd40;
                    else                          d_inv = 1'b1;
                end
                default: d_inv = 1'b1;
            endcase
        end
        // An illegal encoding collapses to the reset-like output pattern.
        if (d_inv) begin
            d_id = 6'd0; d_alu = ALU_NONE; d_imm = 32'd0; d_pc = 32'd4;
            use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_shamt = 1'b0;
        end
        d_rd     = use_rd    ? ir[11:7]  : 5'd0;
        d_rs1    = use_rs1   ? ir[19:15] : 5'd0;
        d_rs2    = use_rs2   ? ir[24:20] : 5'd0;
        d_shamt  = use_shamt ? ir[24:20] : 5'd0;
        d_ovr[0] = (d_rs1 != 5'd0) && (d_rs1 == prev_rd);
        d_ovr[1] = (d_rs2 != 5'd0) && (d_rs2 == prev_rd);
    end

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0; id_q <= 6'd0; alu_q <= ALU_NONE; imm_q <= 32'd0;
            rd_q <= 5'd0; rs1_q <= 5'd0; rs2_q <= 5'd0; shamt_q <= 5'd0;
            pc_q <= 32'd4; ovr_q <= 2'b00; inv_q <= 1'b0; prev_rd <= 5'd0;
        end else begin
            ready_q <= accept;
            if (accept) begin
                id_q <= d_id; alu_q <= d_alu; imm_q <= d_imm;
                rd_q <= d_rd; rs1_q <= d_rs1; rs2_q <= d_rs2; shamt_q <= d_shamt;
                pc_q <= d_pc; ovr_q <= d_ovr; inv_q <= d_inv; prev_rd <= d_rd;
            end
        end
    end

    assign idu.IDU_ready           = ready_q & ~idu.IDU_stall;
    assign idu.Instruction_to_CU   = id_q;
    assign idu.Instruction_to_ALU  = alu_q;
    assign idu.imm                 = imm_q;
    assign idu.rd                  = rd_q;
    assign idu.rs1                 = rs1_q;
    assign idu.rs2                 = rs2_q;
    assign idu.shamt               = shamt_q;
    assign idu.pc_increment        = pc_q;
    assign idu.pipeline_override   = ovr_q;
    assign idu.invalid_instruction = inv_q;
endmodule

// File: tb/tb_cu_id_decoder.sv
// Directed bench for cu_id_decoder: hand-encoded RV32I words with hand-computed decode results.
module tb_cu_id_decoder;
    logic soc_clk = 1'b0;
    logic reset   = 1'b0;
    int   tests   = 0;
    int   fails   = 0;

    cu_id_decoder_if bus ();

    cu_id_decoder dut (
        .soc_clk (soc_clk),
        .reset   (reset),
        .idu     (bus.slave)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dec(input string tag, input logic rdy, input logic [5:0] id,
                             input logic [4:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm, input logic [4:0] shamt,
                             input logic [31:0] pc, input logic [1:0] ovr, input logic inv);
        chk({tag, ".ready"}, {31'd0, bus.IDU_ready}, {31'd0, rdy});
        chk({tag, ".id"},    {26'd0, bus.Instruction_to_CU}, {26'd0, id});
        chk({tag, ".alu"},   {27'd0, bus.Instruction_to_ALU}, {27'd0, alu});
        chk({tag, ".rd"},    {27'd0, bus.rd}, {27'd0, rd});
        chk({tag, ".rs1"},   {27'd0, bus.rs1}, {27'd0, rs1});
        chk({tag, ".rs2"},   {27'd0, bus.rs2}, {27'd0, rs2});
        chk({tag, ".imm"},   bus.imm, imm);
        chk({tag, ".shamt"}, {27'd0, bus.shamt}, {27'd0, shamt});
        chk({tag, ".pc"},    bus.pc_increment, pc);
        chk({tag, ".ovr"},   {30'd0, bus.pipeline_override}, {30'd0, ovr});
        chk({tag, ".inv"},   {31'd0, bus.invalid_instruction}, {31'd0, inv});
    endtask

    task automatic decode(input logic [31:0] ir);
        @(negedge soc_clk);
        bus.Cu_IR        = ir;
        bus.decode_start = 1'b1;
        @(posedge soc_clk);
        #1;
        bus.decode_start = 1'b0;
    endtask

    initial begin
        bus.decode_start = 1'b0;
        bus.IDU_stall    = 1'b0;
        bus.Cu_IR        = 32'd0;
        repeat (2) @(posedge soc_clk);
        #1;
        check_dec("reset", 0, 0, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 0);
        @(negedge soc_clk);
        reset = 1'b1;

        decode(32'h0050_0093);  // addi x1,x0,5
        check_dec("addi", 1, 19, 0, 1, 0, 0, 32'd5, 0, 32'd4, 2'b00, 0);
        decode(32'h0020_81B3);  // add x3,x1,x2 back-to-back
        check_dec("add_raw", 1, 28, 0, 3, 1, 2, 32'd0, 0, 32'd4, 2'b01, 0);
        @(posedge soc_clk);
        #1;
        check_dec("hold", 0, 28, 0, 3, 1, 2, 32'd0, 0, 32'd4, 2'b01, 0);

        decode(32'h0080_00EF);  // jal x1,8
        check_dec("jal", 1, 3, 0, 1, 0, 0, 32'd8, 0, 32'd8, 2'b00, 0);
        decode(32'h0010_81B3);  // add x3,x1,x1
        check_dec("add_both", 1, 28, 0, 3, 1, 1, 32'd0, 0, 32'd4, 2'b11, 0);
        decode(32'h4033_5293);  // srai x5,x6,3
        check_dec("srai", 1, 27, 7, 5, 6, 0, 32'h0000_0403, 3, 32'd4, 2'b00, 0);

        decode(32'hFFFF_FFFF);
        check_dec("illegal", 1, 0, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 1);
        decode(32'hFFC2_A203);  // lw x4,-4(x5); prev_rd cleared by the illegal decode
        check_dec("lw", 1, 13, 0, 4, 5, 0, 32'hFFFF_FFFC, 0, 32'd4, 2'b00, 0);
        decode(32'h0041_2623);  // sw x4,12(x2)
        check_dec("sw", 1, 18, 0, 0, 2, 4, 32'd12, 0, 32'd4, 2'b10, 0);
        decode(32'hFE20_CCE3);  // blt x1,x2,-8
        check_dec("blt", 1, 7, 12, 0, 1, 2, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 2'b00, 0);
        decode(32'h4020_C1B3);  // xor with funct7 0100000
        check_dec("bad_f7", 1, 0, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 1);
        decode(32'h4020_81B3);  // sub x3,x1,x2
        check_dec("sub", 1, 29, 1, 3, 1, 2, 32'd0, 0, 32'd4, 2'b00, 0);
        decode(32'h0000_0073);  // ecall
        check_dec("ecall", 1, 39, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 0);
        decode(32'h0020_0073);  // not ecall/ebreak
        check_dec("bad_sys", 1, 0, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 1);
        decode(32'h1234_53B7);  // lui x7,0x12345
        check_dec("lui", 1, 1, 16, 7, 0, 0, 32'h1234_5000, 0, 32'd4, 2'b00, 0);

        // Request under stall is dropped.
        @(negedge soc_clk);
        bus.IDU_stall    = 1'b1;
        bus.Cu_IR        = 32'h0050_0093;
        bus.decode_start = 1'b1;
        @(posedge soc_clk);
        #1;
        check_dec("stall", 0, 1, 16, 7, 0, 0, 32'h1234_5000, 0, 32'd4, 2'b00, 0);
        bus.decode_start = 1'b0;
        @(negedge soc_clk);
        bus.IDU_stall = 1'b0;

        decode(32'h0013_8413);  // addi x8,x7,1: prev_rd survived the stall
        check_dec("addi_raw", 1, 19, 0, 8, 7, 0, 32'd1, 0, 32'd4, 2'b01, 0);

        // Reset asserted mid-decode.
        @(negedge soc_clk);
        bus.Cu_IR        = 32'h1234_53B7;
        bus.decode_start = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_dec("rst_async", 0, 0, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 0);
        @(posedge soc_clk);
        #1;
        check_dec("rst_edge", 0, 0, 31, 0, 0, 0, 32'd0, 0, 32'd4, 2'b00, 0);
        @(negedge soc_clk);
        bus.decode_start = 1'b0;
        reset = 1'b1;
        @(posedge soc_clk);
        #1;
        chk("rst_no_ready", {31'd0, bus.IDU_ready}, 32'd0);

        decode(32'h0024_0493);  // addi x9,x8,2: prev_rd cleared by reset
        check_dec("post_rst", 1, 19, 0, 9, 8, 0, 32'd2, 0, 32'd4, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
